// File: rtl/mem_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and
// default geometry of the boot ROM window and ack timeout.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int          ADDR_W_DEF  = 16;
   localparam int          DATA_W_DEF  = 8;
   localparam int unsigned ROM_TOP_DEF = 32'h0000_4000;
   localparam int          TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master request/response channels and the shared memory
// port. The arbiter uses the slave view; masters/memory use the master view.
interface mem_arbiter_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_done;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_err;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_done;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_done, m0_rdata, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_done, m1_rdata, m1_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_done, m0_rdata, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_done, m1_rdata, m1_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the master that
// was not granted last wins. Output is the index of the winner.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   // Winner index from the request pair and the last-grant pointer
   always_comb begin
      grant = 1'b0;
      case (req)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between a CPU (master 0) and a DMA/loader
// (master 1). Writes below ROM_TOP are refused at grant time; accesses that
// see no mem_ack within TIMEOUT busy cycles are abandoned with an error.
// All master-facing pulses and the memory command are registered.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int          ADDR_W  = ADDR_W_DEF,
   parameter int          DATA_W  = DATA_W_DEF,
   parameter int unsigned ROM_TOP = ROM_TOP_DEF,
   parameter int          TIMEOUT = TIMEOUT_DEF
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] ROM_LIM  = ADDR_W'(ROM_TOP);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   logic              win;
   logic              last;
   logic              last_nxt;
   logic              owner;
   logic              owner_nxt;
   logic [1:0]        gnt;
   logic [1:0]        gnt_nxt;
   logic [1:0]        done;
   logic [1:0]        done_nxt;
   logic [1:0]        err;
   logic [1:0]        err_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              mem_busy;
   logic              mem_busy_nxt;
   logic              load_cmd;
   logic              cap_rdata;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;

   rr_arb2 u_rr (
      .req   ({bus.m1_req, bus.m0_req}),
      .last  (last),
      .grant (win)
   );

   assign sel_we    = win ? bus.m1_we    : bus.m0_we;
   assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
   assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next state plus the next value of every pulse, pointer and counter
   always_comb begin
      state_nxt    = state;
      gnt_nxt      = 2'b00;
      done_nxt     = 2'b00;
      err_nxt      = 2'b00;
      last_nxt     = last;
      owner_nxt    = owner;
      cnt_nxt      = cnt;
      mem_busy_nxt = mem_busy;
      load_cmd     = 1'b0;
      cap_rdata    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               gnt_nxt[win] = 1'b1;
               last_nxt     = win;
               owner_nxt    = win;
               if (sel_we && (sel_addr < ROM_LIM)) begin
                  // ROM write: refuse at grant, memory never sees it
                  err_nxt[win] = 1'b1;
               end else begin
                  state_nxt    = ST_BUSY;
                  mem_busy_nxt = 1'b1;
                  load_cmd     = 1'b1;
                  cnt_nxt      = '0;
               end
            end
         end
         ST_BUSY: begin
            if (bus.mem_ack) begin
               cap_rdata    = ~cmd_we;
               mem_busy_nxt = 1'b0;
               state_nxt    = ST_RESP;
            end else if (cnt == CNT_LAST) begin
               mem_busy_nxt   = 1'b0;
               err_nxt[owner] = 1'b1;
               state_nxt      = ST_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            done_nxt[owner] = 1'b1;
            state_nxt       = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered outputs, memory command latch and per-master read data
   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt       <= 2'b00;
         done      <= 2'b00;
         err       <= 2'b00;
         last      <= 1'b1;
         owner     <= 1'b0;
         cnt       <= '0;
         mem_busy  <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         gnt      <= gnt_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         last     <= last_nxt;
         owner    <= owner_nxt;
         cnt      <= cnt_nxt;
         mem_busy <= mem_busy_nxt;
         if (load_cmd) begin
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
         end
         if (cap_rdata) begin
            if (owner) rdata1 <= bus.mem_rdata;
            else       rdata0 <= bus.mem_rdata;
         end
      end
   end

   assign bus.m0_gnt    = gnt[0];
   assign bus.m0_done   = done[0];
   assign bus.m0_err    = err[0];
   assign bus.m0_rdata  = rdata0;
   assign bus.m1_gnt    = gnt[1];
   assign bus.m1_done   = done[1];
   assign bus.m1_err    = err[1];
   assign bus.m1_rdata  = rdata1;
   assign bus.mem_req   = mem_busy;
   assign bus.mem_we    = cmd_we;
   assign bus.mem_addr  = cmd_addr;
   assign bus.mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions push expected pulses (cycle,
// flags, both rdata values) into a queue; a negedge monitor pops one entry
// for every gnt/done/err pulse it sees.
module tb_mem_arbiter;

   typedef enum int {K_DONE, K_ROM, K_TMO} kind_t;

   typedef struct {
      int         cyc;
      logic [5:0] flags;
      logic [7:0] rd0;
      logic [7:0] rd1;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] rd0_m = 8'h00;
   logic [7:0] rd1_m = 8'h00;
   bit         mem_req_seen = 1'b0;
   logic [5:0] obs;
   ev_t        e_mon;
   ev_t        exp_q[$];

   mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   mem_arbiter #(
      .ADDR_W  (16),
      .DATA_W  (8),
      .ROM_TOP (32'h4000),
      .TIMEOUT (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Flag layout: {m1_gnt, m1_done, m1_err, m0_gnt, m0_done, m0_err}
   function automatic logic [5:0] fl(input int m, input bit g, input bit d, input bit e);
      logic [2:0] t;
      t = {g, d, e};
      return (m == 0) ? {3'b000, t} : {t, 3'b000};
   endfunction

   task automatic push(input int c, input logic [5:0] f);
      ev_t e;
      e.cyc   = c;
      e.flags = f;
      e.rd0   = rd0_m;
      e.rd1   = rd1_m;
      exp_q.push_back(e);
   endtask

   task automatic set_rd(input int m, input logic [7:0] v);
      if (m == 0) rd0_m = v;
      else        rd1_m = v;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, req);
      end
   endtask

   task automatic set_req(input int m, input bit r, input bit we, input logic [15:0] a,
                          input logic [7:0] d);
      if (m == 0) begin
         bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   // One isolated access; the arbiter must be idle when called
   task automatic xact(input int m, input bit we, input logic [15:0] a, input logic [7:0] d,
                       input kind_t k, input int ack_at, input logic [7:0] rd);
      int g;
      g = cyc + 1;
      case (k)
         K_ROM: push(g, fl(m, 1, 0, 1));
         K_TMO: begin
            push(g, fl(m, 1, 0, 0));
            push(g + 16, fl(m, 0, 0, 1));
         end
         default: begin
            push(g, fl(m, 1, 0, 0));
            if (!we) set_rd(m, rd);
            push(g + ack_at + 1, fl(m, 0, 1, 0));
         end
      endcase
      mem_req_seen = 1'b0;
      set_req(m, 1'b1, we, a, d);
      tick(1);
      set_req(m, 1'b0, 1'b0, 16'h0000, 8'h00);
      case (k)
         K_ROM: begin
            chk("rom_mem_req", bus.mem_req, 0);
            tick(1);
            chk("rom_mem_req_never", mem_req_seen, 0);
         end
         K_TMO: begin
            chk("tmo_mem_req_first", bus.mem_req, 1);
            tick(15);
            chk("tmo_mem_req_held", bus.mem_req, 1);
            tick(1);
            chk("tmo_mem_req_drop", bus.mem_req, 0);
            tick(1);
         end
         default: begin
            chk("cmd_mem_req", bus.mem_req, 1);
            chk("cmd_mem_we", bus.mem_we, we);
            chk("cmd_mem_addr", bus.mem_addr, a);
            if (we) chk("cmd_mem_wdata", bus.mem_wdata, d);
            tick(ack_at - 1);
            bus.mem_ack = 1'b1; bus.mem_rdata = rd;
            tick(1);
            bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
            chk("resp_mem_req", bus.mem_req, 0);
            tick(2);
         end
      endcase
   endtask

   // Both masters request together; 'first' is the hand-chosen winner
   task automatic tie(input int first,
                      input bit we_f, input logic [15:0] a_f, input logic [7:0] d_f,
                      input logic [7:0] r_f,
                      input bit we_s, input logic [15:0] a_s, input logic [7:0] d_s,
                      input logic [7:0] r_s);
      int g;
      int sec;
      sec = 1 - first;
      g   = cyc + 1;
      push(g, fl(first, 1, 0, 0));
      if (!we_f) set_rd(first, r_f);
      push(g + 2, fl(first, 0, 1, 0));
      push(g + 3, fl(sec, 1, 0, 0));
      if (!we_s) set_rd(sec, r_s);
      push(g + 5, fl(sec, 0, 1, 0));
      set_req(first, 1'b1, we_f, a_f, d_f);
      set_req(sec, 1'b1, we_s, a_s, d_s);
      tick(1);
      set_req(first, 1'b0, 1'b0, 16'h0000, 8'h00);
      chk("tie_first_addr", bus.mem_addr, a_f);
      bus.mem_ack = 1'b1; bus.mem_rdata = r_f;
      tick(1);
      bus.mem_ack = 1'b0;
      tick(2);
      set_req(sec, 1'b0, 1'b0, 16'h0000, 8'h00);
      chk("tie_second_addr", bus.mem_addr, a_s);
      bus.mem_ack = 1'b1; bus.mem_rdata = r_s;
      tick(1);
      bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
      tick(2);
   endtask

   // Monitor: every pulse must match the head of the expectation queue
   always @(negedge clk) begin
      if (bus.mem_req === 1'b1) mem_req_seen = 1'b1;
      obs = {bus.m1_gnt, bus.m1_done, bus.m1_err, bus.m0_gnt, bus.m0_done, bus.m0_err};
      if (obs != 6'd0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d got %b expected none", cyc, obs);
         end else begin
            e_mon = exp_q.pop_front();
            if (obs !== e_mon.flags || cyc != e_mon.cyc) begin
               errors++;
               $display("FAIL pulse cyc=%0d got %b expected %b at cyc %0d",
                        cyc, obs, e_mon.flags, e_mon.cyc);
            end
            checks++;
            if (bus.m0_rdata !== e_mon.rd0 || bus.m1_rdata !== e_mon.rd1) begin
               errors++;
               $display("FAIL rdata cyc=%0d got m0=%h m1=%h expected m0=%h m1=%h",
                        cyc, bus.m0_rdata, bus.m1_rdata, e_mon.rd0, e_mon.rd1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      tick(3);
      chk("reset_pulses", {bus.m1_gnt, bus.m1_done, bus.m1_err,
                           bus.m0_gnt, bus.m0_done, bus.m0_err}, 0);
      chk("reset_mem_req_we", {bus.mem_req, bus.mem_we}, 0);
      chk("reset_mem_addr", bus.mem_addr, 0);
      chk("reset_mem_wdata", bus.mem_wdata, 0);
      chk("reset_rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
      rst = 1'b1;

      // Tie straight out of reset: m0 first, then repeat tie: m0 again
      tie(0, 1'b0, 16'h5000, 8'h00, 8'h11, 1'b0, 16'h5001, 8'h00, 8'h22);
      tie(0, 1'b1, 16'h5002, 8'h33, 8'h99, 1'b0, 16'h5003, 8'h00, 8'h44);

      // m0 read of low address, ack on second busy cycle
      xact(0, 1'b0, 16'h0010, 8'h00, K_DONE, 2, 8'hA5);

      // ROM boundary: 3FFF refused, 4000 reaches memory (rdata must not move)
      xact(1, 1'b1, 16'h3FFF, 8'h55, K_ROM, 0, 8'h00);
      xact(1, 1'b1, 16'h4000, 8'h55, K_DONE, 1, 8'hEE);

      // No ack: error after 16 busy cycles, then a normal read
      xact(0, 1'b0, 16'h4100, 8'h00, K_TMO, 0, 8'h00);
      xact(0, 1'b0, 16'h4101, 8'h00, K_DONE, 1, 8'h3C);

      // A refused grant to m1 still moves the pointer, so m0 wins the tie
      xact(1, 1'b1, 16'h2000, 8'h12, K_ROM, 0, 8'h00);
      tie(0, 1'b0, 16'h6000, 8'h00, 8'h5A, 1'b1, 16'h6001, 8'h66, 8'h77);

      // Reset in the middle of a busy access
      begin
         int g;
         g = cyc + 1;
         push(g, fl(1, 1, 0, 0));
         set_req(1, 1'b1, 1'b0, 16'h7000, 8'h00);
         tick(1);
         set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
         chk("abort_mem_req_busy", bus.mem_req, 1);
         tick(1);
         rst = 1'b0;
         tick(1);
         rst = 1'b1;
         rd0_m = 8'h00;
         rd1_m = 8'h00;
         chk("abort_mem_req", bus.mem_req, 0);
         chk("abort_mem_addr", bus.mem_addr, 0);
         chk("abort_rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
         bus.mem_ack = 1'b1; bus.mem_rdata = 8'hC3;
         tick(3);
         bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
         tick(1);
         chk("stray_ack_rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
         chk("stray_ack_mem_req", bus.mem_req, 0);
      end

      xact(0, 1'b0, 16'h7100, 8'h00, K_DONE, 1, 8'h81);

      tick(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
